// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, register bit positions and serializer states
package uart_pkg;

  localparam logic [1:0] OFF_TXD    = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous TX byte FIFO; caller gates push on !full and pop on !empty
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible once count says so.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt
module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0010,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        Mem_rd,
  input  logic        Mem_wr,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        uart_tx,
  output logic        irq
);

  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic          en_q, en_d;
  logic          irq_en_q, irq_en_d;
  logic          overflow_q, overflow_d;

  logic          sel;
  logic [1:0]    off;
  logic          wr_txd, wr_status, wr_ctrl;
  logic          fifo_push, fifo_pop;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word;
  logic          baud_done, can_start;
  logic          unused_bits;

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign off       = addr[3:2];
  assign wr_txd    = sel & Mem_wr & (off == OFF_TXD);
  assign wr_status = sel & Mem_wr & (off == OFF_STATUS);
  assign wr_ctrl   = sel & Mem_wr & (off == OFF_CTRL);
  assign fifo_push = wr_txd & ~fifo_full;
  assign unused_bits = ^{addr[1:0], Write_data[31:8]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (Write_data[7:0]),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    status_word                     = '0;
    status_word[ST_BUSY]            = (state_q != S_IDLE);
    status_word[ST_FULL]            = fifo_full;
    status_word[ST_EMPTY]           = fifo_empty;
    status_word[ST_OVF]             = overflow_q;
    status_word[ST_CNT_LSB +: CW]   = fifo_count;
  end

  always_comb begin
    Read_data = '0;
    if (sel && Mem_rd) begin
      case (off)
        OFF_STATUS: Read_data = status_word;
        OFF_CTRL: begin
          Read_data[CTRL_EN]     = en_q;
          Read_data[CTRL_IRQ_EN] = irq_en_q;
        end
        OFF_TXD:  Read_data = '0;
        OFF_RSVD: Read_data = '0;
        default:  Read_data = '0;
      endcase
    end
  end

  // A dropped push wins over a same-cycle clear so the loss is never hidden.
  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    overflow_d = overflow_q;
    if (wr_ctrl) begin
      en_d     = Write_data[CTRL_EN];
      irq_en_d = Write_data[CTRL_IRQ_EN];
    end
    if (wr_status && Write_data[ST_OVF]) overflow_d = 1'b0;
    if (wr_txd && fifo_full)             overflow_d = 1'b1;
  end

  assign baud_done = (baud_cnt_q == BAUD_LAST);
  assign can_start = en_q & ~fifo_empty;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (can_start) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_rd_data;
          baud_cnt_d = '0;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shift_q[0];
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (can_start) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign irq_d = irq_en_q & fifo_empty & (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b0;
      en_q       <= 1'b1;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_tx = tx_q;
  assign irq     = irq_q;

endmodule
